// File: rtl/tiger_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional single-cycle multiply path: define TIGER_MULDIV_FAST_MUL_EN.
module tiger_muldiv #(
    parameter int unsigned ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPre  = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StPost = 2'd3;

    localparam int unsigned RunCycles = 32 / ITER_BITS;
    localparam logic [4:0]  CntLoad   = 5'(RunCycles - 1);

    logic [1:0]  state_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] wide_q;
    logic        neg_q;
    logic        rem_neg_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] step_wide;
    logic [32:0] sum;
    logic [32:0] trial;
    logic [31:0] diff;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign is_signed = ~op_q[0];
    assign abs_a     = (is_signed && a_q[31]) ? -a_q : a_q;
    assign abs_b     = (is_signed && b_q[31]) ? -b_q : b_q;

    // One RUN cycle retires ITER_BITS product/quotient bits.
    // Multiply: {acc, multiplier} with a_q as multiplicand.
    // Divide: {rem, quot} with b_q as divisor; divisor 0 naturally yields all-ones/dividend.
    always_comb begin
        step_wide = wide_q;
        sum       = '0;
        trial     = '0;
        diff      = '0;
        for (int i = 0; i < int'(ITER_BITS); i++) begin
            if (op_q[1]) begin
                trial = step_wide[63:31];
                diff  = step_wide[62:31] - b_q;
                if (trial >= {1'b0, b_q}) begin
                    step_wide = {diff, step_wide[30:0], 1'b1};
                end else begin
                    step_wide = {step_wide[62:0], 1'b0};
                end
            end else begin
                sum       = {1'b0, step_wide[63:32]} + (step_wide[0] ? {1'b0, a_q} : 33'd0);
                step_wide = {sum, step_wide[31:1]};
            end
        end
    end

    always_comb begin
        prod_fix = neg_q ? -wide_q : wide_q;
        quot_fix = neg_q ? -wide_q[31:0] : wide_q[31:0];
        rem_fix  = rem_neg_q ? -wide_q[63:32] : wide_q[63:32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wide_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= srca;
                        b_q     <= srcb;
                        state_q <= StPre;
                    end else begin
                        if (mthi) hi_q <= srca;
                        if (mtlo) lo_q <= srca;
                    end
                end
                StPre: begin
                    a_q       <= abs_a;
                    b_q       <= abs_b;
                    // Divide by zero keeps an unsigned all-ones quotient.
                    neg_q     <= is_signed & (a_q[31] ^ b_q[31]) & ~(op_q[1] & (b_q == '0));
                    rem_neg_q <= is_signed & a_q[31];
                    cnt_q     <= CntLoad;
                    wide_q    <= {32'b0, (op_q[1] ? abs_a : abs_b)};
                    state_q   <= StRun;
`ifdef TIGER_MULDIV_FAST_MUL_EN
                    if (!op_q[1]) begin
                        wide_q  <= {32'b0, abs_a} * {32'b0, abs_b};
                        state_q <= StPost;
                    end
`endif
                end
                StRun: begin
                    wide_q <= step_wide;
                    if (cnt_q == '0) begin
                        state_q <= StPost;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                StPost: begin
                    if (op_q[1]) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_tiger_muldiv.sv
// Directed bench for tiger_muldiv: expected HI/LO pairs are queued at issue and
// popped when done pulses.
module tb_tiger_muldiv;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [63:0] sb_q[$];

`ifdef TIGER_MULDIV_FAST_MUL_EN
    localparam int MulLat = 2;
`else
    localparam int MulLat = 34;
`endif
    localparam int DivLat = 34;

    tiger_muldiv #(.ITER_BITS(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference {hi, lo} computed from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = 64'(sa * sb); return p; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                p = {r[31:0], q[31:0]};
                return p;
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge (T0); returns 1 ns after T0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input bit with_mtlo);
        if (push) sb_q.push_back(model(o, a, b));
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        mtlo  = with_mtlo;
        step();
        start = 1'b0;
        mtlo  = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Waits for done within a bound, checks latency, then pops and compares.
    task automatic wait_done(input string tag, input int lat);
        int n;
        logic [63:0] exp;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat));
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_hilo"}, {hi, lo}, exp);
        end
    endtask

    initial begin
        logic [31:0] old_lo;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'd0;
        srca    = '0;
        srcb    = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        repeat (2) step();
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        reset_n = 1'b1;
        step();

        // Moves in IDLE.
        mthi = 1'b1;
        srca = 32'h1234_5678;
        step();
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_busy", 64'(busy), 64'd0);
        mthi = 1'b1;
        mtlo = 1'b1;
        srca = 32'hCAFE_F00D;
        step();
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

        // Reset at RUN cycle 10 of a DIV.
        issue(2'd2, 32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (10) step();
        check("mid_run_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        step();
        reset_n = 1'b1;
        step();

        issue(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        wait_done("mult_neg", MulLat);
        step();
        check("done_single_pulse", 64'(done), 64'd0);
        issue(2'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
        wait_done("multu", MulLat);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_done("div_m7_2", DivLat);
        issue(2'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        wait_done("divu_100_7", DivLat);
        issue(2'd3, 32'd5, 32'd0, 1'b1, 1'b0);
        wait_done("divu_by_zero", DivLat);
        issue(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);
        wait_done("div_by_zero", DivLat);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done("div_overflow", DivLat);

        // mtlo during RUN is ignored; HI/LO hold during the operation.
        old_lo = lo;
        issue(2'd3, 32'd77, 32'd5, 1'b1, 1'b0);
        repeat (5) step();
        mtlo = 1'b1;
        srca = 32'hDEAD_BEEF;
        step();
        mtlo = 1'b0;
        check("mtlo_in_run_ignored", 64'(lo), 64'(old_lo));
        wait_done("divu_after_mtlo", DivLat - 6);

        // start + mtlo together: only the arithmetic result lands.
        old_lo = lo;
        issue(2'd3, 32'd9, 32'd4, 1'b1, 1'b1);
        check("start_mtlo_dropped", 64'(lo), 64'(old_lo));
        wait_done("divu_with_mtlo", DivLat - 0);

        // Back-to-back: start issued in the done cycle.
        issue(2'd0, 32'd6, 32'd7, 1'b1, 1'b0);
        wait_done("mult_6x7", MulLat);
        issue(2'd3, 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b0);
        wait_done("b2b_divu", DivLat);

        for (int i = 0; i < 4; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 2) ? 32'($urandom_range(1, 255)) : $urandom;
            issue(ro, ra, rb, 1'b1, 1'b0);
            wait_done("random_op", ro[1] ? DivLat : MulLat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tiger_muldiv.md
# tiger_muldiv

Iterative multiply/divide unit sitting beside the execute-stage ALU. It accepts MULT/MULTU/DIV/DIVU operands from the same source operands the ALU receives and owns the HI/LO architectural registers. It presents HI/LO to the execute result mux for MFHI/MFLO. It raises `busy` so the pipeline control can stall any MFHI/MFLO/MTHI/MTLO or new mul/div issued while an operation is in flight.

## Interface
- `ITER_BITS`, default 1: quotient/product bits retired per RUN cycle. Legal values are 1 and 2. RUN length = 32/ITER_BITS.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srca`  in  32  rs operand: multiplicand or dividend.
- `srcb`  in  32  rt operand: multiplier or divisor.
- `mthi`, `mtlo`  in  1 each  write `srca` into HI or LO; sampled only in IDLE.
- `hi`, `lo`  out  32 each  current HI/LO register contents.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  single-cycle pulse in the cycle HI/LO first show a new mul/div result.

## Operation
- States: IDLE, PRE, RUN, POST.
- IDLE + `start`:
  - Latch `op`, `srca`, `srcb`.
  - Go to PRE.
- PRE, 1 cycle:
  - For signed ops, take absolute values of the operands.
  - Record the result sign: product sign = a^b; quotient sign = a^b; remainder sign = sign of a.
  - Clear the accumulator and load the iteration counter.
  - Go to RUN.
- RUN, 32/ITER_BITS cycles:
  - Multiply: shift-add on a 64-bit {acc, multiplier} register.
  - Divide: restoring shift-subtract on a 64-bit {rem, quot} register.
  - The counter decrements each cycle; at 0, go to POST.
- POST, 1 cycle:
  - Apply the sign fixup (two's-complement negate where the recorded sign is 1).
  - Write HI/LO: multiply gives HI = product[63:32], LO = product[31:0]; divide gives LO = quotient, HI = remainder.
  - Go to IDLE.
- Arithmetic rules:
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO = 32'hFFFF_FFFF, HI = dividend (unsigned and signed alike). RUN is still executed, with no early exit.
  - 0x8000_0000 / 0xFFFF_FFFF (DIV): LO = 0x8000_0000, HI = 0.
- IDLE priority:
  - `start` beats `mthi`/`mtlo`; a simultaneous move is dropped.
  - `mthi` and `mtlo` together write both registers.
- `start`, `mthi`, `mtlo` in a non-IDLE state are ignored. Pipeline control guarantees they are not issued while `busy` is high.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state = IDLE. Reset mid-operation aborts immediately to these values.
- `start` sampled at edge T0: `busy` is high from T0 through the POST edge.
- ITER_BITS=1: PRE at T1, RUN T2..T33, POST T34. New HI/LO and `done` are visible after edge T34, and `busy` falls in that same cycle. Total latency is 34 cycles.
- ITER_BITS=2: latency is 18 cycles.
- `mthi`/`mtlo` update HI/LO visible one cycle after the sampling edge; `busy` stays low.
- `hi`/`lo` hold their old values throughout PRE/RUN.
- Back-to-back: `start` may be asserted in the cycle `done` is high, because state is IDLE then.

## Configuration
- Macro `TIGER_MULDIV_FAST_MUL_EN`.
- Defined:
  - MULT/MULTU bypass RUN and use a single-cycle 64-bit `*` in PRE, going PRE→POST.
  - Multiply latency = 2 cycles.
  - DIV/DIVU are unchanged.
- Undefined:
  - All ops take the iterative path.
  - No hardware multiplier is inferred.

## Test plan
- Reset mid-DIV (assert `reset_n` low at RUN cycle 10) -> `hi` = `lo` = 0, `busy` = 0 on the same cycle; next `start` works normally.
- MULT 0xFFFF_FFFE × 3 -> after 34 cycles `hi` = 0xFFFF_FFFF, `lo` = 0xFFFF_FFFA, `done` pulses once. MULTU same operands -> `hi` = 0x0000_0002, `lo` = 0xFFFF_FFFA.
- DIV −7 / 2 -> `lo` = 0xFFFF_FFFD, `hi` = 0xFFFF_FFFF. DIVU 100 / 7 -> `lo` = 14, `hi` = 2.
- DIVU 5 / 0 -> `lo` = 0xFFFF_FFFF, `hi` = 5. DIV 0x8000_0000 / 0xFFFF_FFFF -> `lo` = 0x8000_0000, `hi` = 0.
- `mthi` with `srca` = 0x1234_5678 in IDLE -> `hi` updated next cycle, `busy` stays 0. `mtlo` asserted during RUN -> `lo` unchanged. `start` + `mtlo` in the same IDLE cycle -> only the mul/div result lands.
- With `TIGER_MULDIV_FAST_MUL_EN` defined: MULT 6 × 7 -> `done` 2 cycles after `start`, `lo` = 42. Then issue `start` in the `done` cycle -> the second op is accepted.
